// File: rtl/em4100_manchester_tx.sv
// EM4100-style 64-bit read-only tag frame generator with Manchester-coded modulation output.
// Parity is folded into the frame register when the ID is captured, so transmit is a plain bit walk.
module em4100_manchester_tx #(
  parameter int unsigned HALF_BIT_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [39:0] id_in_i,
  input  logic        load_i,
  input  logic        enable_i,
  output logic        mod_out_o,
  output logic        busy_o,
  output logic        bit_strobe_o,
  output logic        frame_done_o
);

  localparam int unsigned CntW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StTx} state_e;

  // Frame layout, bit 63 sent first: 9 header ones, 10 x (nibble + even parity),
  // 4 column parities, stop 0.
  function automatic logic [63:0] build_frame(input logic [39:0] id);
    logic [63:0] f;
    logic [3:0]  nib;
    logic [3:0]  col;
    f         = '0;
    f[63:55]  = '1;
    col       = '0;
    for (int r = 0; r < 10; r++) begin
      nib              = id[39-4*r -: 4];
      col              = col ^ nib;
      f[54-5*r -: 5]   = {nib, ^nib};
    end
    f[4:1] = col;
    return f;
  endfunction

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [5:0]       bit_q, bit_d;
  logic [63:0]      frame_q, frame_d;
  logic [63:0]      pend_frame_q, pend_frame_d;
  logic             pend_q, pend_d;

  logic [63:0] id_frame;
  logic        half_end;
  logic        frame_end;

  assign id_frame  = build_frame(id_in_i);
  assign half_end  = (cnt_q == CntW'(HALF_BIT_CYCLES - 1));
  assign frame_end = (state_q == StTx) && half_q && half_end && (bit_q == 6'd63);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    pend_frame_d = pend_frame_q;
    pend_d       = pend_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) frame_d = id_frame;
        if (enable_i) state_d = StTx;
      end
      StTx: begin
        if (load_i) begin
          pend_frame_d = id_frame;
          pend_d       = 1'b1;
        end
        if (half_end) begin
          cnt_d  = '0;
          half_d = ~half_q;
          if (half_q) bit_d = bit_q + 6'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (frame_end) begin
          // A load landing on the boundary cycle itself is newest, so it wins.
          pend_d = 1'b0;
          if (load_i)      frame_d = id_frame;
          else if (pend_q) frame_d = pend_frame_q;
          if (!enable_i) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      frame_q      <= build_frame(40'h0);
      pend_frame_q <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      pend_frame_q <= pend_frame_d;
      pend_q       <= pend_d;
    end
  end

  // Outputs decode straight from registers, so reset clears them without waiting for an edge.
  assign busy_o       = (state_q == StTx);
  assign bit_strobe_o = busy_o && !half_q && (cnt_q == '0);
  assign frame_done_o = frame_end;
  assign mod_out_o    = busy_o && (frame_q[6'd63 - bit_q] ^ half_q);

endmodule
